vsa_mem_subsys: RTL and testbench

Memory subsystem for the 12-bit very simple architecture (VSA) processor. It holds a 32x12 instruction memory and a 32x5 data memory, and serves the core's fetch (PC -> instruction) and data ports (ALUOutput/dataout/wr -> datain) combinationally. It contains a sequential bring-up engine: it clears data memory after reset, then accepts a streamed program/data image over a valid/ready load port. Only after that does it assert run, the clock enable of the core.

---
 rtl/vsa_mem_subsys.sv | 120 ++++++++++++
 tb/tb_vsa_mem_subsys.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/vsa_mem_subsys.sv
// vsa_mem_subsys: memory subsystem for the 12-bit VSA processor.
// Holds a 32x12 instruction memory and a 32x5 data memory. Both core read
// ports are combinational. After reset a bring-up engine zeroes dmem
// (CLEAR), then accepts a streamed image over a valid/ready port (LOAD),
// and only then enables the core (RUN).
//
// Ports:
//   clock, reset_n     master clock, synchronous active-low reset
//   pc / instruction   core fetch port: instruction = imem[pc] in RUN, else 0
//   addr / datain      core load port: datain = dmem[addr] in RUN, else 0
//   dataout, wr        core store port, honoured only in RUN
//   ld_valid/ld_ready  loader handshake; ld_ready is high only in LOAD
//   ld_sel             0 = word goes to imem, 1 = word goes to dmem
//   ld_data, ld_last   loader word and end-of-image marker
//   run                core clock enable, high only in RUN
//   st_count           saturating count of stores accepted in RUN
module vsa_mem_subsys #(
  parameter int AW = 5,
  parameter int IW = 12,
  parameter int DW = 5,
  parameter int CW = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [AW-1:0] pc,
  output logic [IW-1:0] instruction,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] dataout,
  input  logic          wr,
  output logic [DW-1:0] datain,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic          ld_sel,
  input  logic [IW-1:0] ld_data,
  input  logic          ld_last,
  output logic          run,
  output logic [CW-1:0] st_count
);

  localparam int Depth = 1 << AW;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t state, nextState;

  logic [IW-1:0] imem [0:Depth-1];
  logic [DW-1:0] dmem [0:Depth-1];

  logic [AW-1:0] clrPtr;
  logic [AW-1:0] ldPtr;
  logic [AW-1:0] ldAddr;
  logic          prevSel;
  logic          xfer;
  logic          store;

  // A change of target between consecutive transfers restarts the image at
  // address 0. prevSel resets to 0, matching ldPtr=0, so the very first
  // transfer lands at 0 whichever memory it targets.
  assign ldAddr = (ld_sel != prevSel) ? '0 : ldPtr;

  always_ff @(posedge clock) begin
    if (!reset_n) state <= CLEAR;
    else          state <= nextState;
  end

  always_comb begin
    nextState = state;
    xfer      = 1'b0;
    store     = 1'b0;
    unique case (state)
      CLEAR: if (clrPtr == '1) nextState = LOAD;
      LOAD: begin
        xfer = ld_valid;
        if (ld_valid && ld_last) nextState = RUN;
      end
      RUN:     store = wr;
      default: nextState = CLEAR;
    endcase
  end

  assign ld_ready    = (state == LOAD);
  assign run         = (state == RUN);
  assign instruction = run ? imem[pc] : '0;
  assign datain      = run ? dmem[addr] : '0;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      clrPtr   <= '0;
      ldPtr    <= '0;
      prevSel  <= 1'b0;
      st_count <= '0;
    end else begin
      if (state == CLEAR) clrPtr <= clrPtr + 1'b1;
      if (xfer) begin
        ldPtr   <= ldAddr + 1'b1;
        prevSel <= ld_sel;
      end
      if (store && (st_count != '1)) st_count <= st_count + 1'b1;
    end
  end

  // Arrays carry no reset; writes are simply suppressed while reset is held.
  always_ff @(posedge clock) begin
    if (reset_n) begin
      if (state == CLEAR) begin
        dmem[clrPtr] <= '0;
      end else if (xfer) begin
        if (ld_sel) dmem[ldAddr] <= ld_data[DW-1:0];
        else        imem[ldAddr] <= ld_data;
      end else if (store) begin
        dmem[addr] <= dataout;
      end
    end
  end

endmodule

// File: tb/tb_vsa_mem_subsys.sv
// tb_vsa_mem_subsys: directed self-checking bench for vsa_mem_subsys.
module tb_vsa_mem_subsys;

  logic        clock;
  logic        reset_n;
  logic [4:0]  pc;
  logic [11:0] instruction;
  logic [4:0]  addr;
  logic [4:0]  dataout;
  logic        wr;
  logic [4:0]  datain;
  logic        ld_valid;
  logic        ld_ready;
  logic        ld_sel;
  logic [11:0] ld_data;
  logic        ld_last;
  logic        run;
  logic [7:0]  st_count;

  int errCount   = 0;
  int checkCount = 0;

  vsa_mem_subsys #(.AW(5), .IW(12), .DW(5), .CW(8)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .pc          (pc),
    .instruction (instruction),
    .addr        (addr),
    .dataout     (dataout),
    .wr          (wr),
    .datain      (datain),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_sel      (ld_sel),
    .ld_data     (ld_data),
    .ld_last     (ld_last),
    .run         (run),
    .st_count    (st_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Release reset and count posedges until ld_ready rises (bounded).
  task automatic releaseReset(output int n, output logic runSeen);
    @(negedge clock);
    reset_n = 1'b1;
    n = 0;
    runSeen = 1'b0;
    while (!ld_ready && n < 200) begin
      @(posedge clock);
      #1;
      n++;
      runSeen = runSeen | run;
    end
  endtask

  task automatic xfer(input logic sel, input logic [11:0] d, input logic last);
    @(negedge clock);
    ld_valid = 1'b1;
    ld_sel   = sel;
    ld_data  = d;
    ld_last  = last;
    check("load_ready", ld_ready, 1);
    @(posedge clock);
    #1;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      check("stall_ready", ld_ready, 1);
    end
  endtask

  initial begin
    int   n;
    logic runSeen;

    reset_n = 1'b0; pc = '0; addr = '0; dataout = '0; wr = 1'b0;
    ld_valid = 1'b0; ld_sel = 1'b0; ld_data = '0; ld_last = 1'b0;

    // Reset state and CLEAR length
    repeat (2) @(posedge clock);
    #1;
    check("rst_run", run, 0);
    check("rst_ready", ld_ready, 0);
    check("rst_count", st_count, 0);
    releaseReset(n, runSeen);
    check("clear_cycles", n, 32);
    check("clear_run", runSeen, 0);

    // LOAD with a two-cycle stall and a store attempt that must be ignored
    @(negedge clock);
    pc = 5'd0;
    #1;
    check("load_instr_forced", instruction, 0);
    wr = 1'b1; addr = 5'd7; dataout = 5'h1F;
    xfer(1'b0, 12'h601, 1'b0);
    idle(2);
    xfer(1'b0, 12'hA55, 1'b0);
    xfer(1'b0, 12'h3F8, 1'b0);
    wr = 1'b0;
    check("load_still_loading", run, 0);
    xfer(1'b1, 12'h01C, 1'b1);
    check("run_after_last", run, 1);
    check("run_ready_low", ld_ready, 0);

    // RUN reads
    pc = 5'd0; #1; check("imem0", instruction, 12'h601);
    pc = 5'd1; #1; check("imem1", instruction, 12'hA55);
    pc = 5'd2; #1; check("imem2", instruction, 12'h3F8);
    addr = 5'd0; #1; check("dmem0", datain, 5'h1C);
    addr = 5'd1; #1; check("dmem1", datain, 5'h00);
    addr = 5'd7; #1; check("load_wr_ignored", datain, 5'h00);
    check("load_wr_count", st_count, 0);

    // Loader traffic in RUN is ignored
    @(negedge clock);
    ld_valid = 1'b1; ld_sel = 1'b0; ld_data = 12'hFFF; ld_last = 1'b1;
    @(posedge clock);
    #1;
    ld_valid = 1'b0; ld_last = 1'b0;
    pc = 5'd0; #1;
    check("run_ld_ignored", instruction, 12'h601);
    check("run_stays", run, 1);

    // Store with read-during-write
    @(negedge clock);
    wr = 1'b1; addr = 5'd7; dataout = 5'h15;
    #1;
    check("store_old", datain, 5'h00);
    @(posedge clock);
    #1;
    wr = 1'b0;
    #1;
    check("store_new", datain, 5'h15);
    check("store_count1", st_count, 1);

    @(negedge clock);
    wr = 1'b1; addr = 5'd3; dataout = 5'h0A;
    @(posedge clock);
    #1;
    wr = 1'b0;
    #1;
    check("store_a3", datain, 5'h0A);
    check("store_count2", st_count, 2);

    // Reset mid-RUN
    @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    check("midrst_run", run, 0);
    check("midrst_count", st_count, 0);
    releaseReset(n, runSeen);
    check("midrst_clear_cycles", n, 32);
    xfer(1'b1, 12'h005, 1'b1);
    check("reload_run", run, 1);
    addr = 5'd3; #1; check("reclear_a3", datain, 5'h00);
    addr = 5'd7; #1; check("reclear_a7", datain, 5'h00);
    addr = 5'd0; #1; check("reload_d0", datain, 5'h05);
    pc = 5'd0; #1; check("imem_kept0", instruction, 12'h601);
    pc = 5'd1; #1; check("imem_kept1", instruction, 12'hA55);

    // Pointer wrap: 33 imem words, no dmem words
    @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    releaseReset(n, runSeen);
    check("wrap_clear_cycles", n, 32);
    for (int i = 0; i <= 32; i++) xfer(1'b0, 12'(i), (i == 32));
    check("wrap_run", run, 1);
    pc = 5'd0;  #1; check("wrap_imem0", instruction, 12'h020);
    pc = 5'd1;  #1; check("wrap_imem1", instruction, 12'h001);
    pc = 5'd31; #1; check("wrap_imem31", instruction, 12'h01F);
    for (int a = 0; a < 32; a++) begin
      addr = 5'(a);
      #1;
      check("clear_datain", datain, 5'h00);
    end

    // Saturation: 300 consecutive stores
    @(negedge clock);
    addr = 5'd9; dataout = 5'h03; wr = 1'b1;
    repeat (254) @(posedge clock);
    #1;
    check("count_fe", st_count, 8'hFE);
    repeat (46) @(posedge clock);
    #1;
    wr = 1'b0;
    check("count_sat", st_count, 8'hFF);
    #1;
    check("sat_store_data", datain, 5'h03);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
